// File: rtl/mono_rx_merge.sv
// Two-source FWFT merge into a 2-entry FWFT buffer with burst-limited alternating arbitration.
// Define MONO_RX_MERGE_CNT_EN to build the saturating per-source forwarded-word counters.
module mono_rx_merge #(
    parameter int MAX_BURST = 16
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        IN0_FIFO_EMPTY,
    input  logic [31:0] IN0_FIFO_DATA,
    output logic        IN0_FIFO_READ,
    input  logic        IN1_FIFO_EMPTY,
    input  logic [31:0] IN1_FIFO_DATA,
    output logic        IN1_FIFO_READ,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [15:0] CNT0,
    output logic [15:0] CNT1
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state;
    logic [7:0]        burst;
    logic              last;
    logic [1:0]        occ;
    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic              pop0;
    logic              pop1;
    logic              push;
    logic              rd;
    logic              burst_done;
    logic [DATA_W-1:0] push_data;

    // Pops depend only on registered state, occupancy and the source flags.
    assign pop0       = (state == GRANT0) && !IN0_FIFO_EMPTY && (occ < 2'd2);
    assign pop1       = (state == GRANT1) && !IN1_FIFO_EMPTY && (occ < 2'd2);
    assign push       = pop0 || pop1;
    assign push_data  = pop1 ? IN1_FIFO_DATA : IN0_FIFO_DATA;
    assign rd         = FIFO_READ && (occ != 2'd0);
    assign burst_done = ({1'b0, burst} + 9'd1) == 9'(MAX_BURST);

    assign IN0_FIFO_READ = pop0;
    assign IN1_FIFO_READ = pop1;
    assign FIFO_EMPTY    = (occ == 2'd0);
    assign FIFO_DATA     = ent0;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, rd})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                // Push needs occ<2 and read needs occ>0, so both together means occ==1.
                2'b11:   ent0 <= push_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state <= IDLE;
            burst <= '0;
            last  <= 1'b1;
        end else begin
            if (pop0)      last <= 1'b0;
            else if (pop1) last <= 1'b1;

            case (state)
                IDLE: begin
                    burst <= '0;
                    if (!IN0_FIFO_EMPTY && (IN1_FIFO_EMPTY || last)) state <= GRANT0;
                    else if (!IN1_FIFO_EMPTY)                        state <= GRANT1;
                end
                GRANT0: begin
                    if (IN0_FIFO_EMPTY) begin
                        burst <= '0;
                        state <= IN1_FIFO_EMPTY ? IDLE : GRANT1;
                    end else if (pop0) begin
                        if (burst_done) begin
                            burst <= '0;
                            if (!IN1_FIFO_EMPTY) state <= GRANT1;
                        end else begin
                            burst <= burst + 8'd1;
                        end
                    end
                end
                GRANT1: begin
                    if (IN1_FIFO_EMPTY) begin
                        burst <= '0;
                        state <= IN0_FIFO_EMPTY ? IDLE : GRANT0;
                    end else if (pop1) begin
                        if (burst_done) begin
                            burst <= '0;
                            if (!IN0_FIFO_EMPTY) state <= GRANT0;
                        end else begin
                            burst <= burst + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MONO_RX_MERGE_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0 && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
            if (pop1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign CNT0 = cnt0;
    assign CNT1 = cnt1;
`else
    assign CNT0 = '0;
    assign CNT1 = '0;
`endif

endmodule
